init_reply_tx: RTL and testbench

- Transmit-side counterpart of the board's init handshake receiver. On command it serializes a reply string byte-by-byte into the FTDI 245 transmit path using the tx_rq/tx_st four-phase handshake.
- Replies:
  - banner "UTNv2"
  - "OK" (sample rate accepted)
  - "ERR" (sample rate rejected)
  - 2-byte echo of the accepted samp_rate
- Sits between the init FSM (command source) and the FTDI 245 interface (byte sink).

---
 rtl/init_pkg.sv | 38 +++
 rtl/init_reply_rom.sv | 60 ++++++
 rtl/init_reply_tx.sv | 164 ++++++++++++++++
 tb/tb_init_reply_tx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/init_pkg.sv
// init_pkg: definitions shared by the init handshake receiver and the reply
// transmitter.
//   - ASCII byte constants used in the replies
//   - reply command codes (cmd_e)
//   - transmitter state encoding (tx_state_e)
//   - reply lengths in bytes
package init_pkg;

  localparam logic [7:0] ASC_E   = 8'd69;
  localparam logic [7:0] ASC_K   = 8'd75;
  localparam logic [7:0] ASC_N   = 8'd78;
  localparam logic [7:0] ASC_O   = 8'd79;
  localparam logic [7:0] ASC_R   = 8'd82;
  localparam logic [7:0] ASC_T   = 8'd84;
  localparam logic [7:0] ASC_U   = 8'd85;
  localparam logic [7:0] ASC_V   = 8'd118;  // lower-case 'v'
  localparam logic [7:0] ASC_TWO = 8'd50;   // '2'

  typedef enum logic [1:0] {
    CMD_BANNER = 2'd0,
    CMD_OK     = 2'd1,
    CMD_ERR    = 2'd2,
    CMD_RATE   = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_WAIT_REL = 2'd3
  } tx_state_e;

  localparam logic [2:0] LEN_BANNER = 3'd5;
  localparam logic [2:0] LEN_OK     = 3'd2;
  localparam logic [2:0] LEN_ERR    = 3'd3;
  localparam logic [2:0] LEN_RATE   = 3'd2;

endpackage

// File: rtl/init_reply_rom.sv
// init_reply_rom: combinational reply table.
//   cmd_i       reply select (cmd_e encoding)
//   idx_i       byte index within the reply
//   samp_rate_i value echoed by CMD_RATE (high byte first)
//   byte_o      byte at idx_i; 8'h00 for an index past the reply end
//   len_o       reply length in bytes for cmd_i
module init_reply_rom
  import init_pkg::*;
(
  input  logic [1:0]  cmd_i,
  input  logic [2:0]  idx_i,
  input  logic [15:0] samp_rate_i,
  output logic [7:0]  byte_o,
  output logic [2:0]  len_o
);

  always_comb begin
    byte_o = 8'h00;
    len_o  = LEN_BANNER;
    case (cmd_i)
      CMD_BANNER: begin
        len_o = LEN_BANNER;
        case (idx_i)
          3'd0:    byte_o = ASC_U;
          3'd1:    byte_o = ASC_T;
          3'd2:    byte_o = ASC_N;
          3'd3:    byte_o = ASC_V;
          3'd4:    byte_o = ASC_TWO;
          default: byte_o = 8'h00;
        endcase
      end
      CMD_OK: begin
        len_o = LEN_OK;
        case (idx_i)
          3'd0:    byte_o = ASC_O;
          3'd1:    byte_o = ASC_K;
          default: byte_o = 8'h00;
        endcase
      end
      CMD_ERR: begin
        len_o = LEN_ERR;
        case (idx_i)
          3'd0:    byte_o = ASC_E;
          3'd1:    byte_o = ASC_R;
          3'd2:    byte_o = ASC_R;
          default: byte_o = 8'h00;
        endcase
      end
      default: begin
        len_o = LEN_RATE;
        case (idx_i)
          3'd0:    byte_o = samp_rate_i[15:8];
          3'd1:    byte_o = samp_rate_i[7:0];
          default: byte_o = 8'h00;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/init_reply_tx.sv
// init_reply_tx: serializes a reply string into the FTDI 245 transmit path.
//   clk, rst      clock, synchronous active-high reset
//   cmd_valid     request to send reply `cmd` (accepted only while cmd_ready)
//   cmd           0=banner "UTNv2", 1="OK", 2="ERR", 3=samp_rate echo
//   samp_rate     echoed by cmd 3, latched on acceptance
//   cmd_ready     high only in IDLE
//   tx_rq/dato_tx byte request and byte towards the FTDI interface
//   tx_st         FTDI busy/ack, registered once before use
//   busy          reply in progress
//   done          one-cycle pulse when the last byte has been released
//   timeout_err   one-cycle pulse when a reply is aborted on timeout
//
// Handshakes:
//   command side: a command transfers on a rising clk edge where
//     cmd_valid && cmd_ready; cmd_valid while !cmd_ready is dropped, not queued.
//   byte side (four-phase): tx_rq rises with dato_tx valid and both hold
//     until tx_st is seen high; tx_rq then falls and the next byte waits
//     until tx_st is seen low again.
module init_reply_tx
  import init_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter int          TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  input  logic [15:0] samp_rate,
  output logic        cmd_ready,
  output logic        tx_rq,
  output logic [7:0]  dato_tx,
  input  logic        tx_st,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 16'd1);

  tx_state_e       state_q;
  logic [1:0]      cmd_q;
  logic [15:0]     rate_q;
  logic [2:0]      idx_q;
  logic [TO_W-1:0] cnt_q;
  logic            tx_st_q;
  logic            cmd_ready_q, tx_rq_q, busy_q, done_q, to_err_q;
  logic [7:0]      dato_q;

  // One shared table lookup: in IDLE it addresses byte 0 of the incoming
  // command so the first byte is on the wire the cycle after acceptance;
  // otherwise it addresses the byte after the current one.
  logic [1:0]  rom_cmd;
  logic [2:0]  rom_idx;
  logic [15:0] rom_rate;
  logic [7:0]  rom_byte;
  logic [2:0]  rom_len;

  always_comb begin
    rom_cmd  = cmd_q;
    rom_idx  = idx_q + 3'd1;
    rom_rate = rate_q;
    if (state_q == ST_IDLE) begin
      rom_cmd  = cmd;
      rom_idx  = 3'd0;
      rom_rate = samp_rate;
    end
  end

  init_reply_rom u_rom (
    .cmd_i       (rom_cmd),
    .idx_i       (rom_idx),
    .samp_rate_i (rom_rate),
    .byte_o      (rom_byte),
    .len_o       (rom_len)
  );

  // LOAD is the first cycle tx_rq is visible; it is handled like WAIT_ACK so
  // a tx_st that is already high counts as the ack, and the timeout window
  // covers every cycle tx_rq is high for the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 2'd0;
      rate_q      <= 16'h0000;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      tx_st_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      tx_rq_q     <= 1'b0;
      dato_q      <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      tx_st_q  <= tx_st;
      done_q   <= 1'b0;
      to_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q       <= cmd;
            rate_q      <= samp_rate;
            idx_q       <= 3'd0;
            dato_q      <= rom_byte;
            tx_rq_q     <= 1'b1;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD, ST_WAIT_ACK: begin
          if (tx_st_q) begin
            tx_rq_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_WAIT_REL;
          end else if (cnt_q == TO_LAST) begin
            tx_rq_q     <= 1'b0;
            to_err_q    <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_REL: begin
          if (!tx_st_q) begin
            if (idx_q == rom_len - 3'd1) begin
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              dato_q  <= rom_byte;
              tx_rq_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_LOAD;
            end
          end else if (cnt_q == TO_LAST) begin
            to_err_q    <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign tx_rq       = tx_rq_q;
  assign dato_tx     = dato_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_init_reply_tx.sv
module tb_init_reply_tx;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [15:0] samp_rate = 16'h0000;
  logic        cmd_ready, tx_rq, busy, done, timeout_err;
  logic [7:0]  dato_tx;
  logic        tx_st;
  logic        ftdi_st = 1'b0;
  logic        stale_st = 1'b0;

  always #5 clk = ~clk;

  assign tx_st = ftdi_st | stale_st;

  init_reply_tx #(.TIMEOUT_CYC(16'd16), .TO_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .samp_rate   (samp_rate),
    .cmd_ready   (cmd_ready),
    .tx_rq       (tx_rq),
    .dato_tx     (dato_tx),
    .tx_st       (tx_st),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  // ---------------- scoreboard state ----------------
  localparam int EV_DONE = 1;
  localparam int EV_TO   = 2;

  logic [7:0] exp_q[$];
  int         ev_q[$];
  int         checks = 0;
  int         errors = 0;
  int         rise_cnt = 0;

  bit ftdi_en = 1'b0;
  int ack_lo = 0, ack_hi = 0, rel_lo = 0, rel_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_byte(input logic [1:0] c, input int i, input logic [15:0] r);
    string s;
    case (c)
      2'd0: s = "UTNv2";
      2'd1: s = "OK";
      2'd2: s = "ERR";
      default: return (i == 0) ? r[15:8] : r[7:0];
    endcase
    return s[i];
  endfunction

  function automatic int model_len(input logic [1:0] c);
    case (c)
      2'd0: return 5;
      2'd1: return 2;
      2'd2: return 3;
      default: return 2;
    endcase
  endfunction

  // ---------------- FTDI responder ----------------
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (ftdi_en && tx_rq && !rst) begin
        d = $urandom_range(ack_hi, ack_lo);
        repeat (d) @(negedge clk);
        ftdi_st = 1'b1;
        for (int i = 0; i < 200 && tx_rq; i++) @(negedge clk);
        d = $urandom_range(rel_hi, rel_lo);
        repeat (d) @(negedge clk);
        ftdi_st = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic       prev_rq;
    logic [7:0] prev_d;
    prev_rq = 1'b0;
    prev_d  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rq = 1'b0;
        continue;
      end
      check("done_timeout_exclusive", {31'd0, done & timeout_err}, 32'd0);
      check("busy_is_not_ready", {31'd0, busy}, {31'd0, ~cmd_ready});
      if (tx_rq && !prev_rq) begin
        rise_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", dato_tx, $time);
        end else begin
          check("tx_byte", {24'd0, dato_tx}, {24'd0, exp_q.pop_front()});
        end
      end
      if (tx_rq && prev_rq) check("dato_stable", {24'd0, dato_tx}, {24'd0, prev_d});
      if (done || timeout_err) begin
        if (ev_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got done=%0b timeout=%0b expected none (t=%0t)",
                   done, timeout_err, $time);
        end else begin
          check("event_kind", done ? EV_DONE : EV_TO, ev_q.pop_front());
        end
      end
      if (done) check("busy_low_with_done", {31'd0, busy}, 32'd0);
      prev_rq = tx_rq;
      prev_d  = dato_tx;
    end
  end

  // ---------------- driver tasks ----------------
  // nbytes < 0: whole reply expected; ev == 0: no terminating pulse expected.
  task automatic send(input logic [1:0] c, input logic [15:0] r, input int nbytes, input int ev);
    bit ok;
    int n;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready && !rst) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_wait_ready: got cmd_ready=0 expected 1 within 400 cycles");
    end
    cmd       = c;
    samp_rate = r;
    cmd_valid = 1'b1;
    n = (nbytes < 0) ? model_len(c) : nbytes;
    for (int i = 0; i < n; i++) exp_q.push_back(model_byte(c, i, r));
    if (ev != 0) ev_q.push_back(ev);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 2'($urandom);
  endtask

  task automatic poke_while_busy();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    if (busy) begin
      cmd_valid = 1'b1;
      cmd       = 2'($urandom);
      samp_rate = 16'($urandom);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && ev_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_tx_rq"}, {31'd0, tx_rq}, 32'd0);
    check({tag, "_dato_tx"}, {24'd0, dato_tx}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int r0, hi;
    bit seen;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Banner with fixed ack 3 / release 4
    ftdi_en = 1'b1;
    ack_lo = 3; ack_hi = 3; rel_lo = 4; rel_hi = 4;
    r0 = rise_cnt;
    send(2'd0, 16'h0000, -1, EV_DONE);
    drain("banner_drain");
    check("banner_rises", rise_cnt - r0, 5);

    // OK then ERR back to back, with ignored commands while busy
    send(2'd1, 16'h0000, -1, EV_DONE);
    poke_while_busy();
    send(2'd2, 16'h0000, -1, EV_DONE);
    poke_while_busy();
    drain("ok_err_drain");

    // Rate echo; samp_rate changes after acceptance
    send(2'd3, 16'd32000, -1, EV_DONE);
    samp_rate = 16'($urandom);
    repeat (3) @(negedge clk);
    samp_rate = 16'($urandom);
    drain("rate_drain");

    // Timeout: FTDI never acks
    ftdi_en = 1'b0;
    send(2'd1, 16'h0000, 1, EV_TO);
    hi = tx_rq ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_rq) hi++;
      if (timeout_err) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_pulse_seen", {31'd0, seen}, 32'd1);
    check("timeout_rq_cycles", hi, 16);
    @(negedge clk);
    check("timeout_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("timeout_busy_after", {31'd0, busy}, 32'd0);
    drain("timeout_drain");

    // Reset during WAIT_ACK of banner byte 3
    ftdi_en = 1'b1;
    ack_lo = 3; ack_hi = 3; rel_lo = 4; rel_hi = 4;
    r0 = rise_cnt;
    send(2'd0, 16'h0000, 3, 0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (rise_cnt >= r0 + 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("reset_third_byte_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_tx_rq_drop", {31'd0, tx_rq}, 32'd0);
    check_reset_values("midreset");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_no_bytes_left", exp_q.size(), 0);
    send(2'd1, 16'h0000, -1, EV_DONE);
    drain("after_reset_drain");

    // Stale busy: tx_st already high when the reply starts
    ftdi_en = 1'b0;
    ack_lo = 0; ack_hi = 2; rel_lo = 0; rel_hi = 2;
    stale_st = 1'b1;
    repeat (2) @(negedge clk);
    send(2'd2, 16'h0000, -1, EV_DONE);
    @(negedge clk);
    check("stale_ack_rq_low", {31'd0, tx_rq}, 32'd0);
    check("stale_ack_busy", {31'd0, busy}, 32'd1);
    stale_st = 1'b0;
    ftdi_en  = 1'b1;
    drain("stale_drain");

    // Randomized replies with random FTDI timing
    ack_lo = 0; ack_hi = 5; rel_lo = 0; rel_hi = 5;
    for (int k = 0; k < 16; k++) begin
      send(2'($urandom), 16'($urandom), -1, EV_DONE);
      if ($urandom_range(1, 0) == 1) poke_while_busy();
    end
    drain("random_drain");

    repeat (5) @(negedge clk);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_ev_q_empty", ev_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
